// File: rtl/ni_pkg.sv
// Shared defaults, FSM state type and tail-bit helper for the NI FIFO arbiter.
package ni_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TAIL_BIT_DEF   = DATA_WIDTH_DEF - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } state_t;

  // Tail marker is the top bit of a flit of the given width.
  function automatic int tail_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/ni_rr_pick.sv
// Combinational round-robin pick: first requester above last_grant, else the lowest one.
module ni_rr_pick
  import ni_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_any;

  // Descending scan so the last hit is the lowest index in each region.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (i > int'(last_grant)) begin
          hi_idx = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign any    = |req;
  assign winner = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/ni_fifo_arbiter.sv
// Round-robin arbiter draining NUM_REQ FIFOs into one registered valid/ready port.
// Optional packet locking (tail = top flit bit) is enabled by defining NI_ARB_PKT_LOCK_EN.
module ni_fifo_arbiter
  import ni_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_REQ-1:0]            fifo_read_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_src,
  output state_t                        dbg_state
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]        out_src_q, out_src_d;
  logic [NUM_REQ-1:0]      read_en_q, read_en_d;

  logic [NUM_REQ-1:0]      req_vec;
  logic [IDX_W-1:0]        pick;
  logic                    pick_any;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    handshake;

  // A flit transfers on a cycle where out_valid and out_ready are both high;
  // out_data/out_src hold while out_valid is high, and out_ready is ignored otherwise.
  assign handshake = out_valid_q & out_ready;

`ifdef NI_ARB_PKT_LOCK_EN
  localparam int TailBit = tail_bit(DATA_WIDTH);
  logic lock_q, lock_d;

  // While a packet is open only its owner may be granted, even if it is empty.
  assign req_vec = lock_q ? (~fifo_empty & (NUM_REQ'(1) << grant_q)) : ~fifo_empty;

  always_comb begin
    lock_d = lock_q;
    if (handshake) lock_d = ~out_data_q[TailBit];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end
`else
  assign req_vec = ~fifo_empty;
`endif

  ni_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .winner     (pick),
    .any        (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) sel_data = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    read_en_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d   = pick;
          read_en_d = NUM_REQ'(1) << pick;
          state_d   = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // FIFO read data is valid the cycle after its read enable.
        out_data_d  = sel_data;
        out_src_d   = grant_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (handshake) begin
          out_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      read_en_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      read_en_q    <= read_en_d;
    end
  end

  assign fifo_read_en = read_en_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_src      = out_src_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ni_fifo_arbiter.sv
// Bench for ni_fifo_arbiter: behavioural FIFOs, round-robin/lock reference model, directed and random tests.
module tb_ni_fifo_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int SW = 2;
  localparam int W  = SW + DW;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NR-1:0]        fifo_empty;
  logic [NR*DW-1:0]     fifo_data = '0;
  logic [NR-1:0]        fifo_read_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_src;
  ni_pkg::state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int onehot_viol = 0;
  int underflow = 0;
  bit prev_rd = 1'b0;

  // Behavioural FIFOs: storage plus push/pop counters.
  logic [DW-1:0] mem [NR][1024];
  int push_cnt [NR];
  int pop_cnt  [NR];

  // Reference model state.
  logic [DW-1:0] mq [NR][$];
  int m_last;
  bit m_lock;
  int m_lock_src;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];

  ni_fifo_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src      (out_src),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / FIFO model / monitor ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_emp
    assign fifo_empty[g] = (push_cnt[g] == pop_cnt[g]);
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (fifo_read_en[i]) begin
        if (pop_cnt[i] < push_cnt[i]) begin
          fifo_data[i*DW +: DW] = mem[i][pop_cnt[i][9:0]];
          pop_cnt[i]++;
        end else begin
          underflow++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_read_en != '0 && ((fifo_read_en & (fifo_read_en - 1'b1)) != '0)) onehot_viol++;
      if (fifo_read_en != '0 && prev_rd) onehot_viol++;
      prev_rd = (fifo_read_en != '0);
      if (out_valid && out_ready) begin
        got_q.push_back({out_src, out_data});
        got_cyc.push_back(cyc);
      end
    end else begin
      prev_rd = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int i, input logic [DW-1:0] d);
    mem[i][push_cnt[i][9:0]] = d;
    push_cnt[i]++;
    mq[i].push_back(d);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mq[i].delete();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    m_last = NR - 1;
    m_lock = 1'b0;
    m_lock_src = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_model();
  endtask

  task automatic wait_got(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_rd(input int budget);
    int t = 0;
    @(negedge clk);
    while (fifo_read_en == '0 && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Round-robin (and packet lock) reference: drains mq into exp_q in service order.
  task automatic run_model();
    int  idx;
    bit  done = 1'b0;
    logic [DW-1:0] d;
    while (!done) begin
      if (m_lock) begin
        idx = m_lock_src;
      end else begin
        idx = -1;
        for (int off = 1; off <= NR; off++) begin
          if (idx < 0 && mq[(m_last + off) % NR].size() > 0) idx = (m_last + off) % NR;
        end
      end
      if (idx < 0 || mq[idx].size() == 0) begin
        done = 1'b1;
      end else begin
        d = mq[idx].pop_front();
        exp_q.push_back({idx[SW-1:0], d});
        m_last = idx;
`ifdef NI_ARB_PKT_LOCK_EN
        m_lock = !d[DW-1];
        m_lock_src = idx;
`endif
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_src !== '0) begin errors++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
    checks++; if (fifo_read_en !== '0) begin errors++; $display("FAIL reset_read_en: got %b want 0", fifo_read_en); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_idle_empty();
    repeat (20) begin
      @(negedge clk);
      checks++; if (fifo_read_en !== '0) begin errors++; $display("FAIL idle_read_en: got %b want 0", fifo_read_en); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    end
  endtask

  task automatic test_single_fifo();
    logic [DW-1:0] d = 64'hAAAA_AAAA_AAAA_AAAA;
    got_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 push(2, d);
    @(negedge clk);
    checks++; if (fifo_read_en !== 4'b0000) begin errors++; $display("FAIL single_idle_cycle: read_en %b want 0000", fifo_read_en); end
    @(negedge clk);
    checks++; if (fifo_read_en !== 4'b0100) begin errors++; $display("FAIL single_read_en: got %b want 0100", fifo_read_en); end
    @(negedge clk);
    checks++; if (fifo_read_en !== 4'b0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_capt: read_en %b valid %b want 0000/0", fifo_read_en, out_valid);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== d) begin errors++; $display("FAIL single_data: got %h want %h", out_data, d); end
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL single_src: got %0d want 2", out_src); end
    wait_got(1, 10);
    repeat (2) @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d flits want 1", got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d1 = {1'b1, 63'h0123_4567_89AB_CDEF};
    logic [DW-1:0] d3 = {1'b1, 63'h7654_3210_FEDC_BA98};
    int t = 0;
    got_q.delete();
    out_ready = 1'b0;
    @(posedge clk);
    #1 push(1, d1);
    @(negedge clk);
    while (!out_valid && t < 10) begin @(negedge clk); t++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b want 1", out_valid); end
    push(3, d3);
    repeat (10) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== d1) begin errors++; $display("FAIL bp_hold_data: got %h want %h", out_data, d1); end
      checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL bp_hold_src: got %0d want 1", out_src); end
      checks++; if (fifo_read_en !== '0) begin errors++; $display("FAIL bp_no_read: got %b want 0000", fifo_read_en); end
    end
    out_ready = 1'b1;
    wait_got(2, 40);
    checks++; if (got_q.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d flits want 2", got_q.size());
    end else begin
      checks++; if (got_q[0] !== {2'd1, d1}) begin errors++; $display("FAIL bp_flit0: got %h want %h", got_q[0], {2'd1, d1}); end
      checks++; if (got_q[1] !== {2'd3, d3}) begin errors++; $display("FAIL bp_flit1: got %h want %h", got_q[1], {2'd3, d3}); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++) push(i, {1'b1, 31'(i), $urandom()});
    run_model();
    wait_got(8, 80);
    checks++; if (got_q.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d flits want 8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr_flit%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        if (k > 0) begin
          checks++; if (got_cyc[k] - got_cyc[k-1] != 4) begin
            errors++; $display("FAIL rr_spacing%0d: got %0d cycles want 4", k, got_cyc[k] - got_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_pkt_lock();
    logic [W-1:0] exp [4];
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push(1, {1'b0, 63'h11});
    push(1, {1'b0, 63'h22});
    push(1, {1'b1, 63'h33});
    wait_rd(10);
    checks++; if (fifo_read_en !== 4'b0010) begin errors++; $display("FAIL lock_first_read: got %b want 0010", fifo_read_en); end
    push(0, {1'b1, 63'h44});
`ifdef NI_ARB_PKT_LOCK_EN
    exp[0] = {2'd1, 1'b0, 63'h11};
    exp[1] = {2'd1, 1'b0, 63'h22};
    exp[2] = {2'd1, 1'b1, 63'h33};
    exp[3] = {2'd0, 1'b1, 63'h44};
`else
    exp[0] = {2'd1, 1'b0, 63'h11};
    exp[1] = {2'd0, 1'b1, 63'h44};
    exp[2] = {2'd1, 1'b0, 63'h22};
    exp[3] = {2'd1, 1'b1, 63'h33};
`endif
    wait_got(4, 60);
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL lock_count: got %0d flits want 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (got_q[k] !== exp[k]) begin errors++; $display("FAIL lock_flit%0d: got %h want %h", k, got_q[k], exp[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [DW-1:0] a  = {1'b1, 63'hA0A0};
    logic [DW-1:0] b1 = {1'b1, 63'hB1B1};
    logic [DW-1:0] b2 = {1'b1, 63'hB2B2};
    logic [DW-1:0] c  = {1'b1, 63'hC0C0};
    got_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 push(1, a);
    wait_got(1, 20);
    @(posedge clk);
    #1;
    push(2, b1);
    push(2, b2);
    push(0, c);
    wait_rd(10);
    checks++; if (fifo_read_en !== 4'b0100) begin errors++; $display("FAIL rst_mid_read: got %b want 0100", fifo_read_en); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0 || out_src !== '0) begin
      errors++; $display("FAIL rst_mid_out: data %h src %0d want 0/0", out_data, out_src);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_got(3, 60);
    repeat (8) @(negedge clk);
    checks++; if (got_q.size() != 3) begin
      errors++; $display("FAIL rst_mid_count: got %0d flits want 3", got_q.size());
    end else begin
      checks++; if (got_q[0] !== {2'd1, a}) begin errors++; $display("FAIL rst_mid_flit0: got %h want %h", got_q[0], {2'd1, a}); end
      checks++; if (got_q[1] !== {2'd0, c}) begin errors++; $display("FAIL rst_mid_flit1: got %h want %h", got_q[1], {2'd0, c}); end
      checks++; if (got_q[2] !== {2'd2, b2}) begin errors++; $display("FAIL rst_mid_flit2: got %h want %h", got_q[2], {2'd2, b2}); end
    end
  endtask

  task automatic test_random();
    int n;
    int t;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      @(posedge clk);
      #1;
      n = 0;
      for (int i = 0; i < NR; i++) begin
        int cnt = $urandom_range(0, 3);
        if (r == 0 && i == 0 && cnt == 0) cnt = 1;
        for (int k = 0; k < cnt; k++) begin
          logic [DW-1:0] d = {$urandom(), $urandom()};
          if (k == cnt - 1) d[DW-1] = 1'b1;
          push(i, d);
          n++;
        end
      end
      run_model();
      t = 0;
      while (got_q.size() < exp_q.size() && t < 400) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_round%0d_count: got %0d flits want %0d", r, got_q.size(), exp_q.size());
      end
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_total: got %0d flits want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_flit%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_read_en_rules();
    checks++; if (onehot_viol != 0) begin errors++; $display("FAIL read_en_pulse_rules: got %0d violations want 0", onehot_viol); end
    checks++; if (underflow != 0) begin errors++; $display("FAIL read_en_underflow: got %0d reads of empty FIFO want 0", underflow); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      push_cnt[i] = 0;
      pop_cnt[i] = 0;
    end
    reset_n = 1'b0;
    out_ready = 1'b0;
    clear_model();
    test_reset();
    test_idle_empty();
    test_single_fifo();
    test_backpressure();
    test_round_robin();
    test_pkt_lock();
    test_reset_mid_transfer();
    test_random();
    test_read_en_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_fifo_arbiter.md
NI_FIFO_ARBITER -- requirements
Module: ni_fifo_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester FIFOs sharing the output port, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 64: flit width, equal to the FIFO data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  NUM_REQ  per-requester FIFO empty flag; bit i belongs to FIFO i.
REQ-006 fifo_data  input  NUM_REQ*DATA_WIDTH  FIFO read data; slice i at [i*DATA_WIDTH +: DATA_WIDTH], valid the cycle after its read enable.
REQ-007 fifo_read_en  output  NUM_REQ  one-hot read enable to the FIFOs.
REQ-008 out_valid  output  1  out_data holds a flit.
REQ-009 out_ready  input  1  downstream accepts; handshake = out_valid & out_ready.
REQ-010 out_data  output  DATA_WIDTH  registered flit.
REQ-011 out_src  output  clog2(NUM_REQ)  index of the FIFO that supplied out_data.

Function
REQ-012 FSM states IDLE, READ, CAPT, SEND; SHALL move through them in that order, one state per cycle, except as stated below.
REQ-013 IDLE: if any eligible requester (~fifo_empty[i]) exists, SHALL latch the round-robin winner into grant and go to READ; otherwise stay in IDLE.
REQ-014 Round-robin: search starts at last_grant+1 modulo NUM_REQ and takes the first eligible index.
REQ-015 READ: fifo_read_en[grant]=1 for exactly this one cycle; all other bits 0; next state CAPT.
REQ-016 fifo_read_en SHALL be 0 in every state other than READ; at most one bit is ever set.
REQ-017 CAPT: out_data <= fifo_data slice[grant] and out_src <= grant; next state SEND.
REQ-018 SEND: out_valid=1; out_data and out_src held stable until handshake.
REQ-019 On handshake: last_grant <= grant, out_valid drops next cycle, next state IDLE.
REQ-020 Latency: a request seen in IDLE at cycle N gives read_en at N+1 and out_valid at N+3; peak throughput is one flit per 4 cycles when out_ready=1.
REQ-021 fifo_empty SHALL be sampled only in IDLE; changes in other states have no effect.
REQ-022 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-023 reset_n low SHALL asynchronously force state=IDLE, out_valid=0, out_data=0, out_src=0, fifo_read_en=0, grant=0, last_grant=NUM_REQ-1, lock=0.
REQ-024 Reset mid-transfer SHALL drop the flit in progress; the FIFO read already issued is not replayed.
REQ-025 After reset_n deasserts, requester 0 has the highest priority.

Configuration
REQ-026 Macro NI_ARB_PKT_LOCK_EN defined: bit DATA_WIDTH-1 of a flit is the tail marker; a handshake on a non-tail flit sets lock=1 and a tail flit clears it.
REQ-027 While lock=1, IDLE SHALL consider only requester grant and wait, even if other FIFOs are non-empty.
REQ-028 Macro not defined: no lock register; arbitration runs on every flit and bit DATA_WIDTH-1 is ordinary data.

Structure
REQ-029 Package ni_pkg SHALL hold the DATA_WIDTH and NUM_REQ defaults, the FSM state typedef, and the tail-bit index constant.
REQ-030 Combinational round-robin selection SHALL live in sub-module ni_rr_pick (inputs: request vector, last_grant; outputs: winner index, any).

Verification
REQ-031 After reset, fifo_empty=4'b0000, out_ready=1 -> grants in order 0,1,2,3,0, with out_valid every 4th cycle.
REQ-032 Only FIFO 2 non-empty, holding 0x...AA -> read_en=4'b0100 one cycle after IDLE; out_data=0x...AA, out_src=2 two cycles later.
REQ-033 out_ready=0 for 10 cycles while in SEND -> out_valid, out_data and out_src stable for all 10 cycles; no read_en pulses.
REQ-034 With NI_ARB_PKT_LOCK_EN: FIFO 1 sends flits with bit63=0,0,1 while FIFO 0 is non-empty -> all three FIFO 1 flits go out before FIFO 0 is served.
REQ-035 reset_n pulsed low during CAPT -> out_valid=0 immediately and the next grant goes to FIFO 0.
REQ-036 All FIFOs empty for 20 cycles -> stays in IDLE with fifo_read_en=0 and out_valid=0 throughout.
